iterative_alu: RTL and testbench

//  Registered, handshaked ALU for the multicycle datapath. Keeps the 4-bit Control op set and {C,N,V,Z} flags.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/iter_muldiv.sv | 72 +++++++
 rtl/iterative_alu.sv | 170 +++++++++++++++++
 tb/tb_iterative_alu.sv | 334 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcodes, FSM state encoding and flag bit positions for iterative_alu
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_MULU = 4'b0100;
    localparam logic [3:0] OP_DIVU = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b1000;
    localparam logic [3:0] OP_OR   = 4'b1001;
    localparam logic [3:0] OP_NOT  = 4'b1010;
    localparam logic [3:0] OP_NOR  = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_SLTU = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Flags vector is {Carry_Borrow, Negative, Overflow, Zero}
    localparam int FLAG_C = 3;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 0;

endpackage

// File: rtl/iter_muldiv.sv
// rtl/iter_muldiv.sv - one-bit-per-cycle unsigned shift-add multiplier / restoring divider
// Only present when ALU_MULDIV_EN is defined.
`ifdef ALU_MULDIV_EN
module iter_muldiv #(
    parameter int DIGIT = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic             is_div,
    input  logic [DIGIT-1:0] A,
    input  logic [DIGIT-1:0] B,
    output logic             busy,
    output logic             fin,
    output logic [DIGIT-1:0] lo,
    output logic [DIGIT-1:0] hi
);

    localparam int CW = $clog2(DIGIT) + 1;

    logic [CW-1:0]    count;
    logic [DIGIT-1:0] lo_r;
    logic [DIGIT-1:0] hi_r;
    logic [DIGIT-1:0] op_r;
    logic             div_r;
    logic [DIGIT:0]   mul_sum;
    logic [DIGIT:0]   shifted;
    logic [DIGIT:0]   diff;

    // lo/hi present the post-iteration value, so the final step is visible on fin
    always_comb begin
        mul_sum = {1'b0, hi_r} + (lo_r[0] ? {1'b0, op_r} : '0);
        shifted = {hi_r, lo_r[DIGIT-1]};
        diff    = shifted - {1'b0, op_r};
        if (div_r) begin
            hi = diff[DIGIT] ? shifted[DIGIT-1:0] : diff[DIGIT-1:0];
            lo = {lo_r[DIGIT-2:0], ~diff[DIGIT]};
        end else begin
            hi = mul_sum[DIGIT:1];
            lo = {mul_sum[0], lo_r[DIGIT-1:1]};
        end
    end

    assign fin = busy && (count == CW'(DIGIT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy  <= 1'b0;
            count <= '0;
            lo_r  <= '0;
            hi_r  <= '0;
            op_r  <= '0;
            div_r <= 1'b0;
        end else if (go) begin
            busy  <= 1'b1;
            count <= '0;
            lo_r  <= A;
            hi_r  <= '0;
            op_r  <= B;
            div_r <= is_div;
        end else if (busy) begin
            lo_r  <= lo;
            hi_r  <= hi;
            count <= count + CW'(1);
            if (fin) begin
                busy <= 1'b0;
            end
        end
    end

endmodule
`endif

// File: rtl/iterative_alu.sv
// rtl/iterative_alu.sv - registered start/done ALU with {C,N,V,Z} flags
// Iterative MULU/DIVU are built only when ALU_MULDIV_EN is defined.
module iterative_alu
    import alu_pkg::*;
#(
    parameter int DIGIT    = 32,
    parameter int CTRLSIZE = 4,
    parameter int FLAGSIZE = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [CTRLSIZE-1:0] Control,
    input  logic [DIGIT-1:0]    A,
    input  logic [DIGIT-1:0]    B,
    output logic                busy,
    output logic                done,
    output logic [DIGIT-1:0]    Out,
    output logic [DIGIT-1:0]    Out_hi,
    output logic [FLAGSIZE-1:0] Flags
);

    state_t              state;
    state_t              state_nxt;
    logic                load_sc;
    logic [DIGIT-1:0]    sc_out;
    logic [FLAGSIZE-1:0] sc_flags;
    logic [DIGIT:0]      add_sum;
    logic [DIGIT:0]      sub_sum;

    always_comb begin
        sc_out   = '0;
        sc_flags = '0;
        add_sum  = {1'b0, A} + {1'b0, B};
        sub_sum  = {1'b0, A} + {1'b0, ~B} + (DIGIT+1)'(1);
        case (Control)
            OP_ADD: begin
                sc_out           = add_sum[DIGIT-1:0];
                sc_flags[FLAG_C] = add_sum[DIGIT];
                sc_flags[FLAG_V] = (A[DIGIT-1] == B[DIGIT-1]) && (sc_out[DIGIT-1] != A[DIGIT-1]);
                sc_flags[FLAG_N] = sc_flags[FLAG_V] ^ sc_out[DIGIT-1];
            end
            OP_SUB: begin
                sc_out           = sub_sum[DIGIT-1:0];
                sc_flags[FLAG_C] = ~sub_sum[DIGIT];
                sc_flags[FLAG_V] = (A[DIGIT-1] != B[DIGIT-1]) && (sc_out[DIGIT-1] != A[DIGIT-1]);
                sc_flags[FLAG_N] = sc_flags[FLAG_V] ^ sc_out[DIGIT-1];
            end
            OP_AND:  sc_out = A & B;
            OP_OR:   sc_out = A | B;
            OP_NOT:  sc_out = ~A;
            OP_NOR:  sc_out = ~(A | B);
            OP_XOR:  sc_out = A ^ B;
            OP_SLTU: sc_out = DIGIT'(A < B);
            default: sc_out = '0;
        endcase
        sc_flags[FLAG_Z] = (sc_out == '0);
    end

`ifdef ALU_MULDIV_EN
    logic                go;
    logic                load_md;
    logic                is_muldiv;
    logic                div_zero_r;
    logic                md_busy;
    logic                md_fin;
    logic [DIGIT-1:0]    md_lo;
    logic [DIGIT-1:0]    md_hi;
    logic [FLAGSIZE-1:0] md_flags;

    assign is_muldiv = (Control == OP_MULU) || (Control == OP_DIVU);

    iter_muldiv #(.DIGIT(DIGIT)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .go     (go),
        .is_div (Control == OP_DIVU),
        .A      (A),
        .B      (B),
        .busy   (md_busy),
        .fin    (md_fin),
        .lo     (md_lo),
        .hi     (md_hi)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_zero_r <= 1'b0;
        end else if (go) begin
            div_zero_r <= (Control == OP_DIVU) && (B == '0);
        end
    end

    always_comb begin
        md_flags         = '0;
        md_flags[FLAG_V] = div_zero_r;
        md_flags[FLAG_Z] = (md_lo == '0);
    end

    assign busy = (state == S_RUN);
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        load_sc   = 1'b0;
`ifdef ALU_MULDIV_EN
        go        = 1'b0;
        load_md   = 1'b0;
`endif
        case (state)
            S_IDLE: begin
                if (start) begin
`ifdef ALU_MULDIV_EN
                    if (is_muldiv) begin
                        go        = 1'b1;
                        state_nxt = S_RUN;
                    end else
`endif
                    begin
                        load_sc   = 1'b1;
                        state_nxt = S_DONE;
                    end
                end
            end
`ifdef ALU_MULDIV_EN
            S_RUN: begin
                if (md_fin) begin
                    load_md   = 1'b1;
                    state_nxt = S_DONE;
                end
            end
`endif
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Results are written only on entry to DONE and hold until the next one
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Out    <= '0;
            Out_hi <= '0;
            Flags  <= '0;
        end else if (load_sc) begin
            Out    <= sc_out;
            Out_hi <= '0;
            Flags  <= sc_flags;
        end
`ifdef ALU_MULDIV_EN
        else if (load_md) begin
            Out    <= md_lo;
            Out_hi <= md_hi;
            Flags  <= md_flags;
        end
`endif
    end

    assign done = (state == S_DONE);

endmodule

// File: tb/tb_iterative_alu.sv
// tb/tb_iterative_alu.sv - self-checking bench for iterative_alu against an arithmetic reference model
`timescale 1ns/1ps
module tb_iterative_alu;

    logic        clk;
    logic        rst;
    logic        start;
    logic [3:0]  Control;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic        done;
    logic [31:0] Out;
    logic [31:0] Out_hi;
    logic [3:0]  Flags;

    int checks;
    int errors;

    iterative_alu #(.DIGIT(32), .CTRLSIZE(4), .FLAGSIZE(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .Control (Control),
        .A       (A),
        .B       (B),
        .busy    (busy),
        .done    (done),
        .Out     (Out),
        .Out_hi  (Out_hi),
        .Flags   (Flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

    // Reference model: exact integer arithmetic, flags derived from the true results
    task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] o, output logic [31:0] h, output logic [3:0] f,
                         output int lat);
        logic [63:0] wide;
        longint      sx;
        bit          c, n, v;
        o = 0; h = 0; c = 0; n = 0; v = 0; lat = 1;
        case (op)
            4'b0000: begin
                wide = {32'd0, a} + {32'd0, b};
                o = wide[31:0];
                c = wide[32];
                sx = longint'($signed(a)) + longint'($signed(b));
                v = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
                n = (sx < 0);
            end
            4'b0001: begin
                o = a - b;
                c = (a < b);
                sx = longint'($signed(a)) - longint'($signed(b));
                v = (sx > 64'sd2147483647) || (sx < -64'sd2147483648);
                n = (sx < 0);
            end
            4'b1000: o = a & b;
            4'b1001: o = a | b;
            4'b1010: o = ~a;
            4'b1011: o = ~(a | b);
            4'b1100: o = a ^ b;
            4'b1101: o = (a < b) ? 32'd1 : 32'd0;
`ifdef ALU_MULDIV_EN
            4'b0100: begin
                wide = {32'd0, a} * {32'd0, b};
                o = wide[31:0];
                h = wide[63:32];
                lat = 33;
            end
            4'b0101: begin
                if (b == 0) begin
                    o = 32'hFFFFFFFF;
                    h = a;
                    v = 1;
                end else begin
                    o = a / b;
                    h = a % b;
                end
                lat = 33;
            end
`endif
            default: begin
                o = 0;
                h = 0;
            end
        endcase
        f = {c, n, v, (o == 0)};
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'hFFFFFFFF;
            2:       return 32'h80000000;
            3:       return 32'h7FFFFFFF;
            4:       return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Drives one start pulse and measures latency, busy cycles and output stability
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int lat, output int bcnt, output bit held);
        logic [31:0] o0, h0;
        logic [3:0]  f0;
        @(negedge clk);
        Control = op; A = a; B = b; start = 1'b1;
        o0 = Out; h0 = Out_hi; f0 = Flags;
        lat = -1; bcnt = 0; held = 1'b1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            start = 1'b0;
            A = $urandom; B = $urandom; Control = 4'($urandom_range(0, 15));
            if (busy) bcnt++;
            if (done) begin
                lat = i;
                break;
            end
            if (Out !== o0 || Out_hi !== h0 || Flags !== f0) held = 1'b0;
        end
    endtask

    task automatic test_reset;
        int lat, bc;
        bit held;
        rst = 1'b1; start = 1'b0; Control = 0; A = 0; B = 0;
        #3;
        checks++; if (Out !== 0)    begin errors++; $display("FAIL reset_out got %h want 0", Out); end
        checks++; if (Out_hi !== 0) begin errors++; $display("FAIL reset_out_hi got %h want 0", Out_hi); end
        checks++; if (Flags !== 0)  begin errors++; $display("FAIL reset_flags got %b want 0000", Flags); end
        checks++; if (done !== 0)   begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (busy !== 0)   begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        issue(4'b1001, 32'h00F0_0001, 32'h1234_0000, lat, bc, held);
        checks++; if (Out !== 32'h12F4_0001) begin errors++; $display("FAIL pre_reset_or got %h want 12f40001", Out); end
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        checks++; if (Out !== 0)   begin errors++; $display("FAIL async_reset_out got %h want 0", Out); end
        checks++; if (Flags !== 0) begin errors++; $display("FAIL async_reset_flags got %b want 0000", Flags); end
        checks++; if (done !== 0)  begin errors++; $display("FAIL async_reset_done got %b want 0", done); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_add_sub;
        logic [31:0] eo, eh;
        logic [3:0]  ef;
        int el, lat, bc;
        bit held;
        model(4'b0000, 32'h7FFFFFFF, 32'd1, eo, eh, ef, el);
        issue(4'b0000, 32'h7FFFFFFF, 32'd1, lat, bc, held);
        checks++; if (lat !== 1)            begin errors++; $display("FAIL add_latency got %0d want 1", lat); end
        checks++; if (Out !== 32'h80000000) begin errors++; $display("FAIL add_out got %h want 80000000", Out); end
        checks++; if (Flags !== ef)         begin errors++; $display("FAIL add_flags got %b want %b", Flags, ef); end
        checks++; if (Out_hi !== 0)         begin errors++; $display("FAIL add_out_hi got %h want 0", Out_hi); end
        issue(4'b0001, 32'd0, 32'd1, lat, bc, held);
        checks++; if (lat !== 1)            begin errors++; $display("FAIL sub_latency got %0d want 1", lat); end
        checks++; if (Out !== 32'hFFFFFFFF) begin errors++; $display("FAIL sub_out got %h want ffffffff", Out); end
        checks++; if (Flags !== 4'b1100)    begin errors++; $display("FAIL sub_flags got %b want 1100", Flags); end
    endtask

    task automatic test_random_ops;
        logic [31:0] a, b, eo, eh;
        logic [3:0]  op, ef;
        int el, lat, bc;
        bit held;
        for (int n = 0; n < 48; n++) begin
            op = 4'($urandom_range(0, 15));
            a = pick();
            b = pick();
            model(op, a, b, eo, eh, ef, el);
            issue(op, a, b, lat, bc, held);
            checks++; if (lat !== el)    begin errors++; $display("FAIL rand_latency op=%b got %0d want %0d", op, lat, el); end
            checks++; if (Out !== eo)    begin errors++; $display("FAIL rand_out op=%b a=%h b=%h got %h want %h", op, a, b, Out, eo); end
            checks++; if (Out_hi !== eh) begin errors++; $display("FAIL rand_out_hi op=%b a=%h b=%h got %h want %h", op, a, b, Out_hi, eh); end
            checks++; if (Flags !== ef)  begin errors++; $display("FAIL rand_flags op=%b a=%h b=%h got %b want %b", op, a, b, Flags, ef); end
            checks++; if (bc !== el - 1) begin errors++; $display("FAIL rand_busy_cycles op=%b got %0d want %0d", op, bc, el - 1); end
            checks++; if (held !== 1'b1) begin errors++; $display("FAIL rand_outputs_held op=%b got changed want stable", op); end
        end
    endtask

`ifdef ALU_MULDIV_EN
    task automatic test_muldiv;
        int lat, bc;
        bit held;
        issue(4'b0100, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, held);
        checks++; if (lat !== 33)            begin errors++; $display("FAIL mulu_latency got %0d want 33", lat); end
        checks++; if (bc !== 32)             begin errors++; $display("FAIL mulu_busy_cycles got %0d want 32", bc); end
        checks++; if (Out_hi !== 32'hFFFFFFFE) begin errors++; $display("FAIL mulu_hi got %h want fffffffe", Out_hi); end
        checks++; if (Out !== 32'h00000001)  begin errors++; $display("FAIL mulu_lo got %h want 00000001", Out); end
        checks++; if (held !== 1'b1)         begin errors++; $display("FAIL mulu_outputs_held got changed want stable"); end
        issue(4'b0101, 32'd100, 32'd7, lat, bc, held);
        checks++; if (Out !== 32'd14)    begin errors++; $display("FAIL divu_quot got %0d want 14", Out); end
        checks++; if (Out_hi !== 32'd2)  begin errors++; $display("FAIL divu_rem got %0d want 2", Out_hi); end
        checks++; if (Flags !== 4'b0000) begin errors++; $display("FAIL divu_flags got %b want 0000", Flags); end
        issue(4'b0101, 32'd5, 32'd0, lat, bc, held);
        checks++; if (lat !== 33)            begin errors++; $display("FAIL div0_latency got %0d want 33", lat); end
        checks++; if (Out !== 32'hFFFFFFFF)  begin errors++; $display("FAIL div0_quot got %h want ffffffff", Out); end
        checks++; if (Out_hi !== 32'd5)      begin errors++; $display("FAIL div0_rem got %h want 5", Out_hi); end
        checks++; if (Flags[1] !== 1'b1)     begin errors++; $display("FAIL div0_v got %b want 1", Flags[1]); end
    endtask

    task automatic test_handshake;
        logic [31:0] a, b, eo, eh;
        logic [3:0]  ef;
        int el, lat, extra;
        a = $urandom; b = $urandom;
        model(4'b0100, a, b, eo, eh, ef, el);
        @(negedge clk);
        Control = 4'b0100; A = a; B = b; start = 1'b1;
        lat = -1;
        for (int i = 1; i <= 100; i++) begin
            @(negedge clk);
            start = (i == 5);
            Control = 4'b1000; A = $urandom; B = $urandom;
            if (done) begin
                lat = i;
                break;
            end
        end
        start = 1'b0;
        checks++; if (lat !== 33)    begin errors++; $display("FAIL hs_latency got %0d want 33", lat); end
        checks++; if (Out !== eo)    begin errors++; $display("FAIL hs_out got %h want %h", Out, eo); end
        checks++; if (Out_hi !== eh) begin errors++; $display("FAIL hs_out_hi got %h want %h", Out_hi, eh); end
        extra = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (done || busy) extra++;
        end
        checks++; if (extra !== 0) begin errors++; $display("FAIL hs_no_second_op got %0d active cycles want 0", extra); end
    endtask

    task automatic test_reset_in_run;
        int act;
        @(negedge clk);
        Control = 4'b0100; A = $urandom; B = $urandom; start = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL run_busy_before_reset got %b want 1", busy); end
        #2 rst = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL run_reset_busy got %b want 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        act = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || busy) act++;
        end
        checks++; if (act !== 0)  begin errors++; $display("FAIL run_reset_no_done got %0d active cycles want 0", act); end
        checks++; if (Out !== 0)  begin errors++; $display("FAIL run_reset_out got %h want 0", Out); end
    endtask
`else
    task automatic test_muldiv_disabled;
        int lat, bc;
        bit held;
        issue(4'b0100, 32'h1234_5678, 32'h9ABC_DEF0, lat, bc, held);
        checks++; if (lat !== 1)         begin errors++; $display("FAIL mulu_off_latency got %0d want 1", lat); end
        checks++; if (Out !== 0)         begin errors++; $display("FAIL mulu_off_out got %h want 0", Out); end
        checks++; if (Flags !== 4'b0001) begin errors++; $display("FAIL mulu_off_flags got %b want 0001", Flags); end
        checks++; if (bc !== 0)          begin errors++; $display("FAIL mulu_off_busy got %0d want 0", bc); end
        issue(4'b0101, 32'd100, 32'd7, lat, bc, held);
        checks++; if (Out !== 0)         begin errors++; $display("FAIL divu_off_out got %h want 0", Out); end
        checks++; if (Flags !== 4'b0001) begin errors++; $display("FAIL divu_off_flags got %b want 0001", Flags); end
    endtask
`endif

    task automatic test_start_in_done;
        logic [31:0] a, b, exp;
        int lat, bc, act;
        bit held, stable;
        a = $urandom; b = $urandom;
        exp = a ^ b;
        issue(4'b1100, a, b, lat, bc, held);
        Control = 4'b1001; A = ~a; B = ~b; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_pulse_width got %b want 0", done); end
        act = 0; stable = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done) act++;
            if (Out !== exp) stable = 1'b0;
        end
        checks++; if (act !== 0)      begin errors++; $display("FAIL start_in_done_ignored got %0d done cycles want 0", act); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL start_in_done_hold got %h want %h", Out, exp); end
    endtask

    task automatic test_back_to_back;
        logic [31:0] a, b;
        int lat, bc;
        bit held;
        a = $urandom; b = $urandom;
        issue(4'b0000, a, b, lat, bc, held);
        issue(4'b1000, a, b, lat, bc, held);
        checks++; if (lat !== 1)       begin errors++; $display("FAIL b2b_latency got %0d want 1", lat); end
        checks++; if (Out !== (a & b)) begin errors++; $display("FAIL b2b_out got %h want %h", Out, a & b); end
        checks++; if (Out_hi !== 0)    begin errors++; $display("FAIL b2b_out_hi got %h want 0", Out_hi); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset;
        test_add_sub;
        test_random_ops;
`ifdef ALU_MULDIV_EN
        test_muldiv;
        test_handshake;
        test_reset_in_run;
`else
        test_muldiv_disabled;
`endif
        test_start_in_done;
        test_back_to_back;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
